// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Free-running VGA raster timing generator. Horizontal and vertical
//   counters walk the full line/frame (visible area plus porches and sync),
//   and every timing flag is registered from the next counter values so it
//   changes on the same edge as the counters. A PIPE_DLY-deep shift register
//   delays hsync/vsync/valid to line up with pixel data coming back from a
//   pixel-address -> BRAM read pipeline.
//
// Ports
//   clk          pixel clock (single domain)
//   rst          synchronous, active-high reset
//   h_cnt        current horizontal pixel coordinate
//   v_cnt        current vertical line coordinate
//   hsync        horizontal sync, active-low, aligned with h_cnt/v_cnt
//   vsync        vertical sync, active-low, aligned with h_cnt/v_cnt
//   valid        high inside the visible area
//   line_start   one-clock pulse while h_cnt == 0
//   frame_start  one-clock pulse while h_cnt == 0 and v_cnt == 0
//   frame_cnt    count of completed frames (wraps at 16 bits)
//   hsync_d      hsync delayed by PIPE_DLY clocks
//   vsync_d      vsync delayed by PIPE_DLY clocks
//   valid_d      valid delayed by PIPE_DLY clocks
module vga_timing_gen #(
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_DLY = 3
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  h_cnt,
  output logic [9:0]  v_cnt,
  output logic        hsync,
  output logic        vsync,
  output logic        valid,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt,
  output logic        hsync_d,
  output logic        vsync_d,
  output logic        valid_d
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [9:0]          h_cnt_q, h_cnt_d;
  logic [9:0]          v_cnt_q, v_cnt_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                hs_q, hs_d;
  logic                vs_q, vs_d;
  logic                vld_q, vld_d;
  logic                ls_q, ls_d;
  logic                fs_q, fs_d;
  logic [PIPE_DLY-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE_DLY-1:0] vs_pipe_q, vs_pipe_d;
  logic [PIPE_DLY-1:0] vld_pipe_q, vld_pipe_d;
  // One extra bit so the shift works unchanged for PIPE_DLY == 1.
  logic [PIPE_DLY:0]   hs_ext, vs_ext, vld_ext;
  logic                h_wrap, v_wrap;

  // Next counter values and the flags decoded from them.
  always_comb begin
    h_wrap      = (h_cnt_q == H_LAST);
    v_wrap      = (v_cnt_q == V_LAST);
    h_cnt_d     = h_cnt_q + 10'd1;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (h_wrap) begin
      h_cnt_d = 10'd0;
      // Both counters wrap on the same edge, so (H_LAST,V_LAST) goes
      // straight to (0,0) with no intermediate (0,V_LAST) state.
      if (v_wrap) begin
        v_cnt_d     = 10'd0;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end else begin
      h_cnt_d = h_cnt_q + 10'd1;
    end

    // Flags use the next counts so they land on the same edge as the counters.
    hs_d  = ~((h_cnt_d >= HS_FIRST) && (h_cnt_d <= HS_LAST));
    vs_d  = ~((v_cnt_d >= VS_FIRST) && (v_cnt_d <= VS_LAST));
    vld_d = (h_cnt_d < H_VIS_W) && (v_cnt_d < V_VIS_W);
    ls_d  = (h_cnt_d == 10'd0);
    fs_d  = (h_cnt_d == 10'd0) && (v_cnt_d == 10'd0);

    // Bit 0 takes the current live flag; bit PIPE_DLY-1 is the oldest.
    hs_ext     = {hs_pipe_q, hs_q};
    vs_ext     = {vs_pipe_q, vs_q};
    vld_ext    = {vld_pipe_q, vld_q};
    hs_pipe_d  = hs_ext[PIPE_DLY-1:0];
    vs_pipe_d  = vs_ext[PIPE_DLY-1:0];
    vld_pipe_d = vld_ext[PIPE_DLY-1:0];
  end

  // State registers; reset parks the raster at (0,0) with the pipeline idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q     <= 10'd0;
      v_cnt_q     <= 10'd0;
      frame_cnt_q <= 16'd0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      vld_q       <= 1'b1;
      ls_q        <= 1'b1;
      fs_q        <= 1'b1;
      hs_pipe_q   <= {PIPE_DLY{1'b1}};
      vs_pipe_q   <= {PIPE_DLY{1'b1}};
      vld_pipe_q  <= {PIPE_DLY{1'b0}};
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      vld_q       <= vld_d;
      ls_q        <= ls_d;
      fs_q        <= fs_d;
      hs_pipe_q   <= hs_pipe_d;
      vs_pipe_q   <= vs_pipe_d;
      vld_pipe_q  <= vld_pipe_d;
    end
  end

  assign h_cnt       = h_cnt_q;
  assign v_cnt       = v_cnt_q;
  assign frame_cnt   = frame_cnt_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign valid       = vld_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign hsync_d     = hs_pipe_q[PIPE_DLY-1];
  assign vsync_d     = vs_pipe_q[PIPE_DLY-1];
  assign valid_d     = vld_pipe_q[PIPE_DLY-1];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen.
//   u_big   : default 640x480 timing; line-level behaviour, hsync edges,
//             delayed outputs and a mid-frame reset.
//   u_small : a tiny 15x10 raster (8/2/3/2 by 6/1/2/1) so whole frames,
//             the double wrap and frame counting fit in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst_a, rst_b;
  logic [9:0]  a_h, a_v, b_h, b_v;
  logic        a_hs, a_vs, a_vld, a_ls, a_fs, a_hsd, a_vsd, a_vldd;
  logic        b_hs, b_vs, b_vld, b_ls, b_fs, b_hsd, b_vsd, b_vldd;
  logic [15:0] a_fc, b_fc;

  vga_timing_gen u_big (
    .clk(clk), .rst(rst_a), .h_cnt(a_h), .v_cnt(a_v),
    .hsync(a_hs), .vsync(a_vs), .valid(a_vld), .line_start(a_ls),
    .frame_start(a_fs), .frame_cnt(a_fc),
    .hsync_d(a_hsd), .vsync_d(a_vsd), .valid_d(a_vldd)
  );

  vga_timing_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DLY(3)
  ) u_small (
    .clk(clk), .rst(rst_b), .h_cnt(b_h), .v_cnt(b_v),
    .hsync(b_hs), .vsync(b_vs), .valid(b_vld), .line_start(b_ls),
    .frame_start(b_fs), .frame_cnt(b_fc),
    .hsync_d(b_hsd), .vsync_d(b_vsd), .valid_d(b_vldd)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Outputs are sampled on the falling edge, away from the active edge.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int eh, ev, pd;
    int mh, mv, mfc, ph, pv, vs_lo, fs_hits;
    logic l_hs, l_vs, l_vld;
    logic [2:0] h_hs, h_vs, h_vld;

    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) tick();

    // Reset state
    chk("rst_h", a_h, 0);
    chk("rst_v", a_v, 0);
    chk("rst_hsync", a_hs, 1);
    chk("rst_vsync", a_vs, 1);
    chk("rst_valid", a_vld, 1);
    chk("rst_line_start", a_ls, 1);
    chk("rst_frame_start", a_fs, 1);
    chk("rst_frame_cnt", a_fc, 0);
    chk("rst_hsync_d", a_hsd, 1);
    chk("rst_vsync_d", a_vsd, 1);
    chk("rst_valid_d", a_vldd, 0);

    // One full line after release, plus the first clock of line 1
    rst_a = 1'b0;
    for (int i = 1; i <= 800; i++) begin
      eh = i % 800;
      ev = i / 800;
      pd = i - 3;
      tick();
      chk("line_h", a_h, eh);
      chk("line_v", a_v, ev);
      chk("line_hsync", a_hs, (eh >= 656 && eh <= 751) ? 0 : 1);
      chk("line_vsync", a_vs, 1);
      chk("line_valid", a_vld, (eh < 640) ? 1 : 0);
      chk("line_start", a_ls, (eh == 0) ? 1 : 0);
      chk("line_frame_start", a_fs, 0);
      chk("line_hsync_d", a_hsd, (i < 3) ? 1 : ((pd >= 656 && pd <= 751) ? 0 : 1));
      chk("line_valid_d", a_vldd, (i >= 3 && pd < 640) ? 1 : 0);
      if (eh == 655) chk("hsync_at_655", a_hs, 1);
      if (eh == 656) chk("hsync_at_656", a_hs, 0);
      if (eh == 751) chk("hsync_at_751", a_hs, 0);
      if (eh == 752) chk("hsync_at_752", a_hs, 1);
      if (eh == 658) chk("hsync_d_at_658", a_hsd, 1);
      if (eh == 659) chk("hsync_d_at_659", a_hsd, 0);
    end
    chk("line_end_v", a_v, 1);

    // Mid-frame reset at (300,1)
    repeat (300) tick();
    chk("pre_rst_h", a_h, 300);
    chk("pre_rst_v", a_v, 1);
    rst_a = 1'b1;
    tick();
    chk("mid_rst_h", a_h, 0);
    chk("mid_rst_v", a_v, 0);
    chk("mid_rst_frame_cnt", a_fc, 0);
    chk("mid_rst_valid_d", a_vldd, 0);
    chk("mid_rst_hsync_d", a_hsd, 1);
    rst_a = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 1) begin
        chk("resume_h", a_h, 1);
        chk("resume_v", a_v, 0);
        chk("resume_frame_cnt", a_fc, 0);
      end
      chk("resume_valid_d", a_vldd, (k < 3) ? 0 : 1);
    end

    // Small raster: one full frame plus three clocks
    chk("small_rst_h", b_h, 0);
    chk("small_rst_v", b_v, 0);
    rst_b = 1'b0;
    mh = 0; mv = 0; mfc = 0; vs_lo = 0; fs_hits = 0;
    h_hs = 3'b111; h_vs = 3'b111; h_vld = 3'b000;
    for (int s = 1; s <= 153; s++) begin
      ph = mh;
      pv = mv;
      l_hs  = !(ph >= 10 && ph <= 12);
      l_vs  = !(pv >= 7 && pv <= 8);
      l_vld = (ph < 8) && (pv < 6);
      h_hs  = {h_hs[1:0], l_hs};
      h_vs  = {h_vs[1:0], l_vs};
      h_vld = {h_vld[1:0], l_vld};
      if (mh == 14) begin
        mh = 0;
        if (mv == 9) begin
          mv = 0;
          mfc++;
        end else begin
          mv++;
        end
      end else begin
        mh++;
      end
      tick();
      chk("small_h", b_h, mh);
      chk("small_v", b_v, mv);
      chk("small_frame_cnt", b_fc, mfc);
      chk("small_frame_start", b_fs, (mh == 0 && mv == 0) ? 1 : 0);
      chk("small_vsync", b_vs, (mv >= 7 && mv <= 8) ? 0 : 1);
      chk("small_hsync_d", b_hsd, h_hs[2]);
      chk("small_vsync_d", b_vsd, h_vs[2]);
      chk("small_valid_d", b_vldd, h_vld[2]);
      if (b_vs == 1'b0) vs_lo++;
      if (b_fs == 1'b1) fs_hits++;
      if (ph == 14 && pv == 9) begin
        chk("dwrap_h", b_h, 0);
        chk("dwrap_v", b_v, 0);
        chk("dwrap_frame_start", b_fs, 1);
        chk("dwrap_frame_cnt", b_fc, 1);
        chk("dwrap_valid", b_vld, 1);
      end
      if (s == 152) chk("valid_d_before_rise", b_vldd, 0);
      if (s == 153) chk("valid_d_rise", b_vldd, 1);
    end
    chk("vsync_low_clocks", vs_lo, 30);
    chk("frame_start_pulses", fs_hits, 1);
    chk("frame_cnt_after_frame", b_fc, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_VIS, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_VIS, default 480, visible lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 The block SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 The block SHALL have parameter PIPE_DLY, default 3, range 1-8, delay in clocks matching the pixel-address/BRAM pipeline.
REQ-010 Port clk, input, 1: 25 MHz pixel clock, single clock domain.
REQ-011 Port rst, input, 1: reset, synchronous, active-high.
REQ-012 Port h_cnt, output, 10: current horizontal pixel coordinate.
REQ-013 Port v_cnt, output, 10: current vertical line coordinate.
REQ-014 Port hsync, output, 1: horizontal sync, active-low, aligned with h_cnt/v_cnt.
REQ-015 Port vsync, output, 1: vertical sync, active-low, aligned with h_cnt/v_cnt.
REQ-016 Port valid, output, 1: high when the current coordinate is in the visible area.
REQ-017 Port line_start, output, 1: one-clock pulse when h_cnt is 0.
REQ-018 Port frame_start, output, 1: one-clock pulse when h_cnt is 0 and v_cnt is 0.
REQ-019 Port frame_cnt, output, 16: count of completed frames.
REQ-020 Ports hsync_d, vsync_d and valid_d, output, 1 each: hsync, vsync and valid delayed by PIPE_DLY clocks, used to drive the VGA pins alongside the pixel data returned by BRAM.

Function
REQ-021 H_TOT = H_VIS+H_FP+H_SYNC+H_BP (800 by default) and V_TOT = V_VIS+V_FP+V_SYNC+V_BP (525 by default).
REQ-022 h_cnt SHALL increment by 1 every clock and wrap from H_TOT-1 to 0.
REQ-023 v_cnt SHALL increment by 1 only in the clock where h_cnt wraps, and SHALL wrap from V_TOT-1 to 0 at that same edge.
REQ-024 hsync SHALL be 0 exactly when h_cnt is in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] ([656,751] by default), and 1 otherwise.
REQ-025 vsync SHALL be 0 exactly when v_cnt is in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1] ([490,491] by default), for whole lines, and 1 otherwise.
REQ-026 valid SHALL be 1 exactly when h_cnt < H_VIS and v_cnt < V_VIS.
REQ-027 hsync, vsync, valid, line_start and frame_start SHALL be registered outputs, computed from the next counter values, so they change on the same edge as h_cnt/v_cnt with zero skew.
REQ-028 frame_cnt SHALL increment on the edge where both counters wrap to (0,0), and SHALL wrap from 65535 to 0.
REQ-029 hsync_d, vsync_d and valid_d SHALL equal hsync, vsync and valid from exactly PIPE_DLY clocks earlier, through a shift register.
REQ-030 No output SHALL glitch or skip a count at any wrap boundary, including the double wrap (799,524) to (0,0).

Reset
REQ-031 While rst=1 at a clk edge: h_cnt=0, v_cnt=0, hsync=1, vsync=1, valid=1, line_start=1, frame_start=1, frame_cnt=0, and all delay stages hsync_d=1, vsync_d=1, valid_d=0.
REQ-032 A reset asserted mid-frame SHALL abort the frame; after release, counting SHALL resume from (1,0) on the first edge with no frame_cnt increment.
REQ-033 The delayed outputs SHALL show their reset values for PIPE_DLY clocks after release, then track the live outputs.

Verification
REQ-034 Reset, then run 800 clocks -> h_cnt goes 0..799 then 0; v_cnt=1; line_start high at clocks 0 and 800 only.
REQ-035 Run to h_cnt 655, 656, 751 and 752 -> hsync is 1, 0, 0 and 1 respectively; valid is 0 for h_cnt 640-799.
REQ-036 Run a full frame of 420000 clocks -> vsync low for exactly 1600 clocks (v_cnt 490-491); frame_start pulses once; frame_cnt=1.
REQ-037 At (799,524) followed by the next edge -> (0,0), frame_start=1, frame_cnt incremented, and no intermediate (0,524) state.
REQ-038 With PIPE_DLY=3 -> valid_d rises exactly 3 clocks after valid rises at (0,0), and hsync_d falls at h_cnt=659.
REQ-039 Assert rst for 1 clock at (300,200), then release -> next values (1,0), frame_cnt=0, valid_d=0 for 3 clocks.
